l1_mem_responder: RTL and testbench

// - Memory-side endpoint of the L1 refill/writeback port: accepts one cache-line request, holds it for a fixed latency, then returns a response.
// - Sits below the L1D/L1I arbiter; serves both caches from one line-wide backing RAM.
// - Stand-in main memory for simulation and FPGA bring-up.

---
 rtl/l1_mem_responder_if.sv | 26 ++
 rtl/l1_mem_responder.sv | 144 ++++++++++++++
 tb/tb_l1_mem_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/l1_mem_responder_if.sv
// L1 refill/writeback port bundle: request from the arbiter, response from memory.
interface l1_mem_responder_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned CL_BITS = 128,
    parameter int unsigned TAG_W   = 2
);
    logic               mem_req_valid;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic [CL_BITS-1:0] mem_req_store_data;
    logic [TAG_W-1:0]   mem_req_tag;
    logic [3:0]         mem_req_opcode;

    logic               mem_rsp_valid;
    logic [CL_BITS-1:0] mem_rsp_load_data;
    logic [TAG_W-1:0]   mem_rsp_tag;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_tag, mem_req_opcode,
        input  mem_rsp_valid, mem_rsp_load_data, mem_rsp_tag
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_tag, mem_req_opcode,
        output mem_rsp_valid, mem_rsp_load_data, mem_rsp_tag
    );
endinterface

// File: rtl/l1_mem_responder.sv
// Fixed-latency line-wide backing memory serving one L1 request at a time.
// Optional MEM_RSP_STATS_EN builds the load/store response counters.
module l1_mem_responder #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LG_CL_BYTES = 4,
    parameter int unsigned LG_LINES    = 12,
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned TAG_W       = 2,
    parameter logic [3:0]  OP_LOAD     = 4'd4,
    parameter logic [3:0]  OP_STORE    = 4'd7
) (
    input  logic                clk,
    input  logic                reset_n,
    l1_mem_responder_if.slave   mem,
    output logic                busy,
    output logic                bad_op,
    output logic [31:0]         load_count,
    output logic [31:0]         store_count
);
    localparam int unsigned CL_BITS = 8 << LG_CL_BYTES;
    localparam int unsigned LINES   = 1 << LG_LINES;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LG_LINES-1:0]  idx_q;
    logic [3:0]           op_q;
    logic [CL_BITS-1:0]   data_q;
    logic [TAG_W-1:0]     tag_q;

    logic                 accept_c;
    logic                 enter_resp_c;
    logic [LG_LINES-1:0]  req_idx_c;
    logic [LG_LINES-1:0]  rsp_idx_c;
    logic [3:0]           rsp_op_c;
    logic [TAG_W-1:0]     rsp_tag_c;

    logic [CL_BITS-1:0]   ram [LINES];

    // Offset and alias bits of the address are intentionally dropped.
    logic unused_addr_c;
    assign unused_addr_c = ^{mem.mem_req_addr[ADDR_W-1:LG_CL_BYTES+LG_LINES],
                             mem.mem_req_addr[LG_CL_BYTES-1:0]};

    assign req_idx_c = mem.mem_req_addr[LG_CL_BYTES+LG_LINES-1:LG_CL_BYTES];

    // With LATENCY==1 the response is formed on the accept edge, so bypass the latches.
    assign rsp_idx_c = accept_c ? req_idx_c          : idx_q;
    assign rsp_op_c  = accept_c ? mem.mem_req_opcode : op_q;
    assign rsp_tag_c = accept_c ? mem.mem_req_tag    : tag_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: cnt counts down the WAIT cycles; RESP is always a single cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem.mem_req_valid) begin
                    accept_c = 1'b1;
                    cnt_d    = CNT_W'(LATENCY - 1);
                    state_d  = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp_c = (state_d == RESP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q  <= '0;
            op_q   <= '0;
            data_q <= '0;
            tag_q  <= '0;
        end else if (accept_c) begin
            idx_q  <= req_idx_c;
            op_q   <= mem.mem_req_opcode;
            data_q <= mem.mem_req_store_data;
            tag_q  <= mem.mem_req_tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem.mem_rsp_valid     <= 1'b0;
            mem.mem_rsp_load_data <= '0;
            mem.mem_rsp_tag       <= '0;
            busy                  <= 1'b0;
            bad_op                <= 1'b0;
        end else begin
            mem.mem_rsp_valid <= enter_resp_c;
            busy              <= (state_d != IDLE);
            if (enter_resp_c) begin
                mem.mem_rsp_tag       <= rsp_tag_c;
                mem.mem_rsp_load_data <= (rsp_op_c == OP_LOAD) ? ram[rsp_idx_c] : '0;
                if (rsp_op_c != OP_LOAD && rsp_op_c != OP_STORE) bad_op <= 1'b1;
            end
        end
    end

    // Stores commit during the RESP cycle; RAM survives reset.
    always_ff @(posedge clk) begin
        if (state_q == RESP && op_q == OP_STORE) ram[idx_q] <= data_q;
    end

`ifdef MEM_RSP_STATS_EN
    logic [31:0] load_cnt_q, store_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else if (enter_resp_c) begin
            if (rsp_op_c == OP_LOAD)  load_cnt_q  <= load_cnt_q + 32'd1;
            if (rsp_op_c == OP_STORE) store_cnt_q <= store_cnt_q + 32'd1;
        end
    end

    assign load_count  = load_cnt_q;
    assign store_count = store_cnt_q;
`else
    assign load_count  = 32'd0;
    assign store_count = 32'd0;
`endif
endmodule

// File: tb/tb_l1_mem_responder.sv
// Bench for l1_mem_responder: LATENCY=4 and LATENCY=1 instances, vector table plus corner sequences.
module tb_l1_mem_responder;
    localparam logic [3:0] OP_LD = 4'd4;
    localparam logic [3:0] OP_ST = 4'd7;
`ifdef MEM_RSP_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    l1_mem_responder_if #(.ADDR_W(32), .CL_BITS(128), .TAG_W(2)) bus4 ();
    l1_mem_responder_if #(.ADDR_W(32), .CL_BITS(128), .TAG_W(2)) bus1 ();

    logic        busy4, bad4, busy1, bad1;
    logic [31:0] lc4, sc4, lc1, sc1;

    l1_mem_responder #(.LATENCY(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .mem(bus4),
        .busy(busy4), .bad_op(bad4), .load_count(lc4), .store_count(sc4));

    l1_mem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .mem(bus1),
        .busy(busy1), .bad_op(bad1), .load_count(lc1), .store_count(sc1));

    typedef struct packed {
        logic [127:0] data;
        logic [1:0]   tag;
    } exp_t;

    typedef struct {
        logic [3:0]   op;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [1:0]   tag;
        logic [127:0] exp;
    } vec_t;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;
    vec_t vecs[8];

    int pass_cnt = 0;
    int total_cnt = 0;
    int n_ld = 0;
    int n_st = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return STATS_EN ? 32'(n) : 32'd0;
    endfunction

    // Scoreboards: every response must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && bus4.mem_rsp_valid === 1'b1) begin
            if (q4.size() == 0) check("rsp4_unexpected", 128'(bus4.mem_rsp_valid), 128'(0));
            else begin
                e4 = q4.pop_front();
                check("rsp4_data", bus4.mem_rsp_load_data, e4.data);
                check("rsp4_tag", 128'(bus4.mem_rsp_tag), 128'(e4.tag));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && bus1.mem_rsp_valid === 1'b1) begin
            if (q1.size() == 0) check("rsp1_unexpected", 128'(bus1.mem_rsp_valid), 128'(0));
            else begin
                e1 = q1.pop_front();
                check("rsp1_data", bus1.mem_rsp_load_data, e1.data);
                check("rsp1_tag", 128'(bus1.mem_rsp_tag), 128'(e1.tag));
            end
        end
    end

    // One request on the LATENCY=4 port: latency, busy window, single pulse, hold.
    task automatic req4(input logic [3:0] op, input logic [31:0] addr, input logic [127:0] data,
                        input logic [1:0] tag, input logic [127:0] exp);
        bit got;
        @(negedge clk);
        bus4.mem_req_opcode     = op;
        bus4.mem_req_addr       = addr;
        bus4.mem_req_store_data = data;
        bus4.mem_req_tag        = tag;
        bus4.mem_req_valid      = 1'b1;
        q4.push_back('{data: exp, tag: tag});
        got = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("busy4", 128'(busy4), 128'(1));
            if (bus4.mem_rsp_valid === 1'b1) begin
                check("lat4", 128'(k), 128'(4));
                got = 1'b1;
                break;
            end
        end
        if (!got) check("timeout4", 128'(bus4.mem_rsp_valid), 128'(1));
        bus4.mem_req_valid = 1'b0;
        if (op == OP_LD) n_ld++;
        if (op == OP_ST) n_st++;
        @(negedge clk);
        check("pulse4_end", 128'(bus4.mem_rsp_valid), 128'(0));
        check("hold4_data", bus4.mem_rsp_load_data, exp);
        check("hold4_tag", 128'(bus4.mem_rsp_tag), 128'(tag));
        check("idle4_busy", 128'(busy4), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        vecs[0] = '{OP_ST, 32'h0000_0040, {16{8'hA5}}, 2'd1, 128'd0};
        vecs[1] = '{OP_LD, 32'h0000_0040, 128'd0,      2'd2, {16{8'hA5}}};
        vecs[2] = '{OP_LD, 32'h0000_004F, 128'd0,      2'd3, {16{8'hA5}}};
        vecs[3] = '{OP_ST, 32'h0001_0040, {16{8'h5A}}, 2'd0, 128'd0};
        vecs[4] = '{OP_LD, 32'h0000_0040, 128'd0,      2'd1, {16{8'h5A}}};
        vecs[5] = '{OP_ST, 32'h0000_0080, 128'h0123456789ABCDEF_FEDCBA9876543210, 2'd2, 128'd0};
        vecs[6] = '{OP_LD, 32'h0000_008C, 128'd0,      2'd0, 128'h0123456789ABCDEF_FEDCBA9876543210};
        vecs[7] = '{OP_LD, 32'h0000_0040, 128'd0,      2'd3, {16{8'h5A}}};

        bus4.mem_req_valid = 1'b0; bus4.mem_req_addr = '0; bus4.mem_req_store_data = '0;
        bus4.mem_req_tag = '0; bus4.mem_req_opcode = '0;
        bus1.mem_req_valid = 1'b0; bus1.mem_req_addr = '0; bus1.mem_req_store_data = '0;
        bus1.mem_req_tag = '0; bus1.mem_req_opcode = '0;

        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 128'(bus4.mem_rsp_valid), 128'(0));
        check("rst_load_data", bus4.mem_rsp_load_data, 128'(0));
        check("rst_tag", 128'(bus4.mem_rsp_tag), 128'(0));
        check("rst_busy", 128'(busy4), 128'(0));
        check("rst_bad_op", 128'(bad4), 128'(0));
        check("rst_load_count", 128'(lc4), 128'(0));
        check("rst_store_count", 128'(sc4), 128'(0));
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++)
            req4(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].tag, vecs[i].exp);
        check("load_count", 128'(lc4), 128'(exp_cnt(n_ld)));
        check("store_count", 128'(sc4), 128'(exp_cnt(n_st)));

        // Unknown opcode: zero data, sticky flag, counters and RAM untouched.
        req4(4'd9, 32'h0000_0080, {16{8'hFF}}, 2'd1, 128'd0);
        check("bad_op_set", 128'(bad4), 128'(1));
        check("bad_op_load_count", 128'(lc4), 128'(exp_cnt(n_ld)));
        req4(OP_LD, 32'h0000_0080, 128'd0, 2'd0, 128'h0123456789ABCDEF_FEDCBA9876543210);
        check("bad_op_sticky", 128'(bad4), 128'(1));

        // Reset in WAIT: in-flight store dropped, outputs cleared at once.
        @(negedge clk);
        bus4.mem_req_opcode = OP_ST; bus4.mem_req_addr = 32'h40;
        bus4.mem_req_store_data = {16{8'h11}}; bus4.mem_req_tag = 2'd3;
        bus4.mem_req_valid = 1'b1;
        @(negedge clk);
        check("abort_busy", 128'(busy4), 128'(1));
        @(negedge clk);
        reset_n = 1'b0;
        bus4.mem_req_valid = 1'b0;
        #1;
        check("abort_busy_clr", 128'(busy4), 128'(0));
        check("abort_rsp_valid", 128'(bus4.mem_rsp_valid), 128'(0));
        check("abort_data_clr", bus4.mem_rsp_load_data, 128'(0));
        check("abort_tag_clr", 128'(bus4.mem_rsp_tag), 128'(0));
        check("abort_bad_clr", 128'(bad4), 128'(0));
        check("abort_lc_clr", 128'(lc4), 128'(0));
        n_ld = 0;
        n_st = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        req4(OP_LD, 32'h0000_0040, 128'd0, 2'd2, {16{8'h5A}});

        // LATENCY=1: store, then loads with valid held continuously.
        @(negedge clk);
        bus1.mem_req_opcode = OP_ST; bus1.mem_req_addr = 32'h40;
        bus1.mem_req_store_data = {16{8'hC3}}; bus1.mem_req_tag = 2'd0;
        bus1.mem_req_valid = 1'b1;
        q1.push_back('{data: 128'd0, tag: 2'd0});
        @(negedge clk);
        check("l1_store_rsp", 128'(bus1.mem_rsp_valid), 128'(1));
        bus1.mem_req_valid = 1'b0;
        @(negedge clk);
        check("l1_store_pulse_end", 128'(bus1.mem_rsp_valid), 128'(0));

        bus1.mem_req_opcode = OP_LD; bus1.mem_req_tag = 2'd2;
        bus1.mem_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) q1.push_back('{data: {16{8'hC3}}, tag: 2'd2});
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("l1_pulse", 128'(bus1.mem_rsp_valid), 128'(k % 2));
            if (bus1.mem_rsp_valid === 1'b1) pulses++;
        end
        bus1.mem_req_valid = 1'b0;
        check("l1_pulse_count", 128'(pulses), 128'(10));
        @(negedge clk);
        check("l1_queue_drained", 128'(q1.size()), 128'(0));
        check("l1_load_count", 128'(lc1), 128'(exp_cnt(10)));
        check("l1_store_count", 128'(sc1), 128'(exp_cnt(1)));
        check("final_load_count", 128'(lc4), 128'(exp_cnt(n_ld)));
        check("q4_drained", 128'(q4.size()), 128'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
